// File: rtl/noc_port_requester_if.sv
// Handshake bundle between one NoC input port, its requester front end and the judge.
// The master modport is the requester's view; slave is the upstream/judge side.
interface noc_port_requester_if #(
  parameter int DW  = 16,
  parameter int RCW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [1:0]     dout;
  logic           fail;
  logic [DW-1:0]  out_data;
  logic           out_fire;
  logic [RCW-1:0] retry_cnt;
  logic           starve;

  modport master (
    input  in_valid, in_data, fail,
    output in_ready, dout, out_data, out_fire, retry_cnt, starve
  );

  modport slave (
    output in_valid, in_data, fail,
    input  in_ready, dout, out_data, out_fire, retry_cnt, starve
  );
endinterface

// File: rtl/noc_port_requester.sv
// Per-input-port NoC front end: FIFO-buffers packets, routes the head (X first, then Y,
// then LOCAL) and holds it toward the judge until a non-failed cycle pops it.
module noc_port_requester #(
  parameter int DW        = 16,
  parameter int CW        = 2,
  parameter int DEPTH     = 4,
  parameter int RCW       = 4,
  parameter int STARVE_TH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CW-1:0]        cur_x,
  input  logic [CW-1:0]        cur_y,
  noc_port_requester_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RETRY = 2'd2
  } state_t;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_X     = 2'b01;
  localparam logic [1:0] DIR_Y     = 2'b10;
  localparam logic [1:0] DIR_LOCAL = 2'b11;

  state_t         state_q, state_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [RCW-1:0] retry_q, retry_d;
  logic [DW-1:0]  mem_q [DEPTH];

  logic           empty, full, empty_nxt, push, pop;
  logic [DW-1:0]  head;

  function automatic logic [1:0] route(input logic [DW-1:0] pkt,
                                       input logic [CW-1:0] cx,
                                       input logic [CW-1:0] cy);
    logic [1:0] dir;
    if (pkt[DW-1 -: CW] != cx)         dir = DIR_X;
    else if (pkt[DW-CW-1 -: CW] != cy) dir = DIR_Y;
    else                               dir = DIR_LOCAL;
    return dir;
  endfunction

  function automatic logic [RCW-1:0] sat_inc(input logic [RCW-1:0] v);
    return (v == {RCW{1'b1}}) ? v : v + RCW'(1);
  endfunction

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Outputs are gated by empty so that an async reset forces dout/out_data to zero at once.
  always_comb begin
    bus.in_ready  = !full;
    bus.dout      = empty ? DIR_NONE : route(head, cur_x, cur_y);
    bus.out_data  = empty ? '0 : head;
    bus.out_fire  = !empty && !bus.fail;
    bus.retry_cnt = retry_q;
    bus.starve    = (retry_q >= RCW'(STARVE_TH));
  end

  assign push = bus.in_valid && !full;
  assign pop  = bus.out_fire;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
    empty_nxt = (wr_ptr_d == rd_ptr_d);
    state_d   = state_q;
    retry_d   = retry_q;
    if (pop) begin
      retry_d = '0;
      state_d = empty_nxt ? IDLE : REQ;
    end else if (!empty) begin
      // Non-empty without a pop means the judge failed us this cycle.
      retry_d = (state_q == RETRY) ? sat_inc(retry_q) : RCW'(1);
      state_d = RETRY;
    end else begin
      retry_d = '0;
      state_d = empty_nxt ? IDLE : REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      retry_q  <= retry_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
  end

endmodule
